// File: rtl/muldiv_ctrl.sv
// Sequencing controller between the MIPS EX stage and the iterative HI/LO multiply/divide unit.
// Issues one HI/LO instruction at a time, waits out MULT/DIV, and reports completion/exceptions.
module muldiv_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 200,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [5:0]            i_funct,
  input  logic [DATA_WIDTH-1:0] i_rs_data,
  input  logic [DATA_WIDTH-1:0] i_rt_data,
  input  logic                  i_flush,
  output logic                  o_md_en,
  output logic [2:0]            o_md_op,
  output logic [DATA_WIDTH-1:0] o_md_a,
  output logic [DATA_WIDTH-1:0] o_md_b,
  input  logic                  i_md_busy,
  input  logic                  i_md_div_zero,
  input  logic [DATA_WIDTH-1:0] i_md_dout,
  output logic                  o_done,
  output logic                  o_result_valid,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_exc_div_zero,
  output logic                  o_exc_timeout,
  output logic                  o_illegal,
  output logic                  o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_e                state_q;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  killed_q;
  logic                  done_q;
  logic                  rvalid_q;
  logic                  divz_q;
  logic                  tmo_q;
  logic                  illegal_q;

  logic [2:0]            op_d;
  logic                  legal_d;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  killed_d;

  // Legal functs are 0x10-0x13 and 0x18-0x1B; the unit opcode is then {funct[3], funct[1:0]}.
  assign op_d     = {i_funct[3], i_funct[1:0]};
  assign legal_d  = (i_funct[5:4] == 2'b01) && !i_funct[2];
  assign cnt_d    = cnt_q + CNT_WIDTH'(1);
  assign killed_d = killed_q | i_flush;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      killed_q  <= 1'b0;
      done_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      divz_q    <= 1'b0;
      tmo_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      divz_q    <= 1'b0;
      tmo_q     <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req_valid && !i_flush) begin
            op_q <= op_d;
            a_q  <= i_rs_data;
            b_q  <= i_rt_data;
            if (legal_d) begin
              state_q <= ISSUE;
            end else begin
              state_q   <= RESP;
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (i_flush) begin
            state_q <= IDLE;
          end else if (op_q[2]) begin
            if (i_md_div_zero) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              divz_q  <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= '0;
            end
          end else begin
            state_q <= RESP;
            done_q  <= 1'b1;
            if (!op_q[0]) begin
              result_q <= i_md_dout;
              rvalid_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          cnt_q    <= cnt_d;
          killed_q <= killed_d;
          // A killed operation still waits for the unit, which cannot be aborted.
          if (!i_md_busy && cnt_q != '0) begin
            state_q <= RESP;
            done_q  <= !killed_d;
          end else if (i_md_busy && cnt_q == TMO_LAST) begin
            state_q <= RESP;
            done_q  <= !killed_d;
            tmo_q   <= !killed_d;
          end
        end
        RESP: begin
          state_q  <= IDLE;
          killed_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready    = (state_q == IDLE);
  assign o_busy         = (state_q != IDLE);
  assign o_md_en        = (state_q == ISSUE) && !i_flush;
  assign o_md_op        = op_q;
  assign o_md_a         = a_q;
  assign o_md_b         = b_q;
  assign o_done         = done_q;
  assign o_result_valid = rvalid_q;
  assign o_result       = result_q;
  assign o_exc_div_zero = divz_q;
  assign o_exc_timeout  = tmo_q;
  assign o_illegal      = illegal_q;

endmodule
